// File: rtl/vend_pkg.sv
// Shared encodings for the vending controller: state codes, keypad codes
// and the coin-key value map.
package vend_pkg;

  localparam int unsigned STATE_W = 3;

  // Enum values double as the display_state codes shown on D3-D5.
  typedef enum logic [STATE_W-1:0] {
    ST_IDLE     = 3'd0,
    ST_SELECT   = 3'd1,
    ST_PRICE    = 3'd2,
    ST_QTY      = 3'd3,
    ST_CONFIRM  = 3'd4,
    ST_PAY      = 3'd5,
    ST_DISPENSE = 3'd6
  } state_t;

  localparam logic [3:0] KEY_CANCEL  = 4'h0;
  localparam logic [3:0] KEY_COIN_2  = 4'h4;
  localparam logic [3:0] KEY_COIN_5  = 4'h5;
  localparam logic [3:0] KEY_COIN_10 = 4'h6;
  localparam logic [3:0] KEY_TAKE    = 4'h7;
  localparam logic [3:0] KEY_INC     = 4'hA;
  localparam logic [3:0] KEY_DEC     = 4'hB;
  localparam logic [3:0] KEY_OK      = 4'hC;
  localparam logic [3:0] KEY_CONFIRM = 4'hD;
  localparam logic [3:0] KEY_NEXT    = 4'hE;
  localparam logic [3:0] KEY_START   = 4'hF;

  // Zero means "not a coin key".
  function automatic logic [3:0] coin_value(input logic [3:0] key);
    case (key)
      KEY_COIN_2:  coin_value = 4'd2;
      KEY_COIN_5:  coin_value = 4'd5;
      KEY_COIN_10: coin_value = 4'd10;
      default:     coin_value = 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/vend_timeout_timer.sv
// Idle timer: counts cycles since the last clear and flags expiry once it
// reaches TIMEOUT_CYC-1, holding there until cleared.
module vend_timeout_timer #(
  parameter int unsigned TIMEOUT_CYC = 50000000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic expire
);

  localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] count_q, count_d;

  // NOTE: every variable written here gets a value before any branch, so no
  // path leaves it unassigned and no latch can be inferred.
  always_comb begin
    count_d = count_q;
    if (clear)
      count_d = '0;
    else if (count_q != LAST)
      count_d = count_q + CNT_W'(1);
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign expire = (count_q == LAST);

endmodule

// File: rtl/vend_fsm_param.sv
// Parametrised vending-machine controller: select, quantity, payment,
// change, cancel/refund and idle timeout, with fully registered outputs.
module vend_fsm_param
  import vend_pkg::*;
#(
  parameter int unsigned NUM_PRODUCTS = 8,
  parameter int unsigned PRICE_W      = 8,
  parameter int unsigned QTY_MAX      = 9,
  parameter int unsigned TIMEOUT_CYC  = 50000000,
  parameter logic [NUM_PRODUCTS*PRICE_W-1:0] PRICE_TABLE = {
    PRICE_W'(20), PRICE_W'(20), PRICE_W'(20), PRICE_W'(2),
    PRICE_W'(5),  PRICE_W'(10), PRICE_W'(12), PRICE_W'(15)}
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    key_valid,
  input  logic [3:0]              key_code,
  input  logic [NUM_PRODUCTS-1:0] stock_empty,
  output logic [PRICE_W-1:0]      display_value,
  output logic [2:0]              display_state,
  output logic                    dispense,
  output logic [3:0]              dispense_id,
  output logic                    change_valid,
  output logic [PRICE_W-1:0]      change_amount,
  output logic                    error
);

  localparam int unsigned QTY_W  = $clog2(QTY_MAX + 1);
  localparam int unsigned PROD_W = PRICE_W + QTY_W;
  localparam logic [PRICE_W-1:0] PRICE_MAX = '1;

  state_t              state_q, state_d;
  logic [3:0]          sel_q, sel_d;
  logic [QTY_W-1:0]    qty_q, qty_d;
  logic [PRICE_W-1:0]  total_q, total_d;
  logic [PRICE_W-1:0]  credit_q, credit_d;
  logic [PRICE_W-1:0]  change_q, change_d;

  logic [PRICE_W-1:0]  display_q, display_d;
  logic                dispense_q, dispense_d;
  logic [3:0]          dispense_id_q, dispense_id_d;
  logic                change_valid_q, change_valid_d;
  logic [PRICE_W-1:0]  change_amount_q, change_amount_d;
  logic                error_q, error_d;

  // Lookups indexed directly by the 4-bit product number; unused slots read 0.
  logic [PRICE_W-1:0] price_arr [16];
  logic [15:0]        sold_out;

  for (genvar g = 0; g < 16; g++) begin : g_prod
    if (g >= 1 && g <= NUM_PRODUCTS) begin : g_on
      assign price_arr[g] = PRICE_TABLE[(g-1)*PRICE_W +: PRICE_W];
      assign sold_out[g]  = stock_empty[g-1];
    end else begin : g_off
      assign price_arr[g] = '0;
      assign sold_out[g]  = 1'b0;
    end
  end

  logic timer_clear, timer_expire;

  assign timer_clear = key_valid || (state_q == ST_IDLE) || (state_q == ST_DISPENSE);

  vend_timeout_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (timer_clear),
    .expire (timer_expire)
  );

  logic [PROD_W-1:0] qty_price;
  logic [31:0]       credit_sum;
  logic [3:0]        coin;
  logic              is_product;
  logic              abort;

  always_comb begin
    state_d         = state_q;
    sel_d           = sel_q;
    qty_d           = qty_q;
    total_d         = total_q;
    credit_d        = credit_q;
    change_d        = change_q;
    dispense_d      = 1'b0;
    dispense_id_d   = '0;
    change_valid_d  = 1'b0;
    change_amount_d = '0;
    error_d         = 1'b0;
    display_d       = '0;

    qty_price  = PROD_W'(qty_q) * PROD_W'(price_arr[sel_q]);
    coin       = coin_value(key_code);
    credit_sum = 32'(credit_q) + 32'(coin);
    is_product = (key_code != 4'd0) && (32'(key_code) <= NUM_PRODUCTS);

    unique case (state_q)
      ST_IDLE:
        if (key_valid && key_code == KEY_START) state_d = ST_SELECT;
      ST_SELECT:
        if (key_valid && is_product) begin
          if (sold_out[key_code]) begin
            error_d = 1'b1;
          end else begin
            sel_d   = key_code;
            state_d = ST_PRICE;
          end
        end
      ST_PRICE:
        if (key_valid && key_code == KEY_OK) begin
          qty_d   = QTY_W'(1);
          state_d = ST_QTY;
        end
      ST_QTY:
        if (key_valid) begin
          case (key_code)
            KEY_INC:
              if (qty_q == QTY_W'(QTY_MAX)) error_d = 1'b1;
              else                          qty_d   = qty_q + QTY_W'(1);
            KEY_DEC:
              if (qty_q == QTY_W'(1)) error_d = 1'b1;
              else                    qty_d   = qty_q - QTY_W'(1);
            KEY_NEXT:
              if (qty_price > PROD_W'(PRICE_MAX)) begin
                error_d = 1'b1;
              end else begin
                total_d = qty_price[PRICE_W-1:0];
                state_d = ST_CONFIRM;
              end
            default: ;
          endcase
        end
      ST_CONFIRM:
        if (key_valid && key_code == KEY_CONFIRM) begin
          credit_d = '0;
          state_d  = ST_PAY;
        end
      ST_PAY:
        // Payment completes one cycle after the covering coin registers.
        if (credit_q >= total_q) begin
          change_d = credit_q - total_q;
          state_d  = ST_DISPENSE;
        end else if (key_valid && coin != 4'd0) begin
          if (credit_sum > 32'(PRICE_MAX)) error_d  = 1'b1;
          else                             credit_d = credit_sum[PRICE_W-1:0];
        end
      ST_DISPENSE:
        if (key_valid && key_code == KEY_TAKE) begin
          dispense_d      = 1'b1;
          dispense_id_d   = sel_q;
          change_valid_d  = 1'b1;
          change_amount_d = change_q;
          state_d         = ST_IDLE;
        end
      default:
        state_d = ST_IDLE;
    endcase

    // Cancel and timeout share one exit; a key in the expiry cycle wins.
    abort = (state_q != ST_IDLE) && (state_q != ST_DISPENSE) &&
            ((key_valid && key_code == KEY_CANCEL) || (!key_valid && timer_expire));
    if (abort) begin
      state_d  = ST_IDLE;
      error_d  = 1'b0;
      credit_d = '0;
      if (credit_q != '0) begin
        change_valid_d  = 1'b1;
        change_amount_d = credit_q;
      end
    end

    unique case (state_d)
      ST_PRICE:    display_d = price_arr[sel_d];
      ST_QTY:      display_d = PRICE_W'(qty_d);
      ST_CONFIRM:  display_d = total_d;
      ST_PAY:      display_d = credit_d;
      ST_DISPENSE: display_d = change_d;
      default:     display_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      sel_q           <= '0;
      qty_q           <= '0;
      total_q         <= '0;
      credit_q        <= '0;
      change_q        <= '0;
      display_q       <= '0;
      dispense_q      <= 1'b0;
      dispense_id_q   <= '0;
      change_valid_q  <= 1'b0;
      change_amount_q <= '0;
      error_q         <= 1'b0;
    end else begin
      state_q         <= state_d;
      sel_q           <= sel_d;
      qty_q           <= qty_d;
      total_q         <= total_d;
      credit_q        <= credit_d;
      change_q        <= change_d;
      display_q       <= display_d;
      dispense_q      <= dispense_d;
      dispense_id_q   <= dispense_id_d;
      change_valid_q  <= change_valid_d;
      change_amount_q <= change_amount_d;
      error_q         <= error_d;
    end
  end

  assign display_value = display_q;
  assign display_state = state_q;
  assign dispense      = dispense_q;
  assign dispense_id   = dispense_id_q;
  assign change_valid  = change_valid_q;
  assign change_amount = change_amount_q;
  assign error         = error_q;

endmodule
